// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch PC, 2-entry prefetch queue and redirect handling; optional misaligned-redirect trap via IF_MISALIGN_TRAP_EN
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_dout_i,
  output logic              id_valid_o,
  output logic [31:0]       id_inst_o,
  output logic [31:0]       id_pc_o,
  input  logic              id_ready_i,
  input  logic              redir_valid_i,
  input  logic [31:0]       redir_pc_i,
  output logic              fault_o,
  output logic [31:0]       fault_pc_o
);
  typedef enum logic {FETCH, HALT} state_t;
  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] q_pc_q [2];
  logic [31:0] q_inst_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q;
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic        pop, push, redir, mis;
`ifdef IF_MISALIGN_TRAP_EN
  assign mis = redir_pc_i[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  assign redir      = redir_valid_i && state_q == FETCH;
  assign id_valid_o = cnt_q != 2'd0;
  assign id_inst_o  = id_valid_o ? q_inst_q[rd_ptr_q] : 32'h0;
  assign id_pc_o    = id_valid_o ? q_pc_q[rd_ptr_q] : 32'h0;
  assign rom_addr_o = fetch_pc_q[ADDR_W+1:2];
  assign fault_o    = fault_q;
  assign fault_pc_o = fault_pc_q;
  assign pop        = id_valid_o && id_ready_i;
  assign push       = state_q == FETCH && !redir && (cnt_q != 2'd2 || pop);
  // fetch PC, queue bookkeeping and fault state; a redirect flushes the queue and wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= PC_RESET;
      q_pc_q[0]   <= '0;
      q_pc_q[1]   <= '0;
      q_inst_q[0] <= '0;
      q_inst_q[1] <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
    end else if (redir) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      if (mis) begin
        state_q    <= HALT;
        fault_q    <= 1'b1;
        fault_pc_q <= redir_pc_i;
      end else begin
        fetch_pc_q <= redir_pc_i & ~32'h3;
      end
    end else begin
      if (push) begin
        q_pc_q[wr_ptr_q]   <= fetch_pc_q;
        q_inst_q[wr_ptr_q] <= rom_dout_i;
        wr_ptr_q           <= ~wr_ptr_q;
        fetch_pc_q         <= fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: scoreboard bench for if_fetch_ctrl with a behavioural ROM
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        id_valid;
  logic [31:0] id_inst, id_pc;
  logic        id_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        fault;
  logic [31:0] fault_pc;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  if_fetch_ctrl #(.PC_RESET(32'h0), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr), .rom_dout_i(rom_dout),
    .id_valid_o(id_valid), .id_inst_o(id_inst), .id_pc_o(id_pc), .id_ready_i(id_ready),
    .redir_valid_i(redir_valid), .redir_pc_i(redir_pc), .fault_o(fault), .fault_pc_o(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [5:0] a);
    return {16'hC0DE, 2'b00, a, 2'b00, a};
  endfunction

  assign rom_dout = rom_word(rom_addr);

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(logic [31:0] pc);
    exp_q.push_back({pc, rom_word(pc[7:2])});
  endtask

  task automatic restart();
    rst = 1'b1;
    id_ready = 1'b0;
    redir_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // monitor: a transfer is seen at the negedge before the edge that completes it
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", id_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_pc", id_pc, e[63:32]);
        chk("xfer_inst", id_inst, e[31:0]);
      end
    end
  end

  initial begin
    step();
    step();
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_rom_addr", {26'b0, rom_addr}, 32'h0);
    // stream from reset with decode always ready
    rst = 1'b0;
    id_ready = 1'b1;
    expect_xfer(32'h0);
    expect_xfer(32'h4);
    expect_xfer(32'h8);
    for (int i = 0; i < 4; i++) step();
    id_ready = 1'b0;
    // backpressure: queue fills in two cycles then fetch holds
    restart();
    for (int i = 0; i < 5; i++) step();
    chk("full_rom_addr", {26'b0, rom_addr}, 32'd2);
    chk("full_valid", {31'b0, id_valid}, 32'h1);
    chk("full_pc", id_pc, 32'h0);
    chk("full_inst", id_inst, rom_word(6'd0));
    id_ready = 1'b1;
    expect_xfer(32'h0);
    expect_xfer(32'h4);
    expect_xfer(32'h8);
    expect_xfer(32'hC);
    for (int i = 0; i < 4; i++) begin
      chk("no_bubble_valid", {31'b0, id_valid}, 32'h1);
      step();
    end
    id_ready = 1'b0;
    // redirect while full
    restart();
    for (int i = 0; i < 3; i++) step();
    redir_valid = 1'b1;
    redir_pc = 32'h20;
    step();
    redir_valid = 1'b0;
    chk("redir_valid_low", {31'b0, id_valid}, 32'h0);
    chk("redir_pc_zero", id_pc, 32'h0);
    chk("redir_inst_zero", id_inst, 32'h0);
    step();
    chk("redir_valid_high", {31'b0, id_valid}, 32'h1);
    chk("redir_head_pc", id_pc, 32'h20);
    chk("redir_head_inst", id_inst, rom_word(6'd8));
    id_ready = 1'b1;
    expect_xfer(32'h20);
    expect_xfer(32'h24);
    step();
    step();
    id_ready = 1'b0;
    // fetch across the ROM wrap
    restart();
    step();
    step();
    redir_valid = 1'b1;
    redir_pc = 32'hFC;
    step();
    redir_valid = 1'b0;
    chk("wrap_rom_addr_63", {26'b0, rom_addr}, 32'd63);
    id_ready = 1'b1;
    expect_xfer(32'hFC);
    expect_xfer(32'h100);
    step();
    chk("wrap_rom_addr_0", {26'b0, rom_addr}, 32'd0);
    step();
    step();
    id_ready = 1'b0;
    // misaligned redirect
    restart();
    step();
    step();
    redir_valid = 1'b1;
    redir_pc = 32'h22;
    step();
    redir_valid = 1'b0;
    chk("mis_valid_low", {31'b0, id_valid}, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_fault_pc", fault_pc, 32'h22);
    for (int i = 0; i < 3; i++) step();
    chk("mis_halt_valid", {31'b0, id_valid}, 32'h0);
`else
    chk("mis_fault", {31'b0, fault}, 32'h0);
    chk("mis_fault_pc", fault_pc, 32'h0);
    chk("mis_rom_addr", {26'b0, rom_addr}, 32'd8);
    step();
    chk("mis_resume_valid", {31'b0, id_valid}, 32'h1);
    chk("mis_resume_pc", id_pc, 32'h20);
`endif
    // asynchronous reset mid-stream with the queue full
    restart();
    for (int i = 0; i < 3; i++) step();
    chk("pre_arst_valid", {31'b0, id_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_inst", id_inst, 32'h0);
    chk("arst_rom_addr", {26'b0, rom_addr}, 32'h0);
    chk("arst_fault", {31'b0, fault}, 32'h0);
    chk("arst_fault_pc", fault_pc, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_arst_pc", id_pc, 32'h0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
